// File: rtl/wb_arbiter.sv
// Writeback arbiter for the integer register file: load-priority with execute aging,
// registered write port, optional busy scoreboard (compile with WB_SCOREBOARD_EN).
module wb_arbiter #(
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    output logic        ex_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic [4:0]  rf_a2,
    output logic [31:0] rf_din,
    output logic        rf_reg_wr,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy
);

    localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);

    logic [3:0]  age_reg;
    logic [3:0]  age_next;
    logic        ld_win;
    logic        ex_win;
    logic        accept;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic [4:0]  rf_a2_reg;
    logic [31:0] rf_din_reg;
    logic        rf_wr_reg;

    // Load wins unless execute has aged out; execute takes any cycle load does not.
    always_comb begin
        ld_win = ld_valid && ((age_reg < AGE_MAX) || !ex_valid);
        ex_win = ex_valid && !ld_win;
    end

    assign ld_ready = rst && ld_win;
    assign ex_ready = rst && ex_win;

    always_comb begin
        age_next = 4'd0;
        if (ex_valid && !ex_win) begin
            age_next = (age_reg == AGE_MAX) ? age_reg : age_reg + 4'd1;
        end
    end

    always_comb begin
        accept   = ld_win || ex_win;
        sel_rd   = ld_win ? ld_rd : ex_rd;
        sel_data = ld_win ? ld_data : ex_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_reg    <= 4'd0;
            rf_a2_reg  <= 5'd0;
            rf_din_reg <= 32'd0;
            rf_wr_reg  <= 1'b0;
        end else begin
            age_reg <= age_next;
            if (accept) begin
                rf_a2_reg  <= sel_rd;
                rf_din_reg <= sel_data;
                rf_wr_reg  <= (sel_rd != 5'd0);
            end else begin
                rf_wr_reg  <= 1'b0;
            end
        end
    end

    assign rf_a2     = rf_a2_reg;
    assign rf_din    = rf_din_reg;
    assign rf_reg_wr = rf_wr_reg;

`ifdef WB_SCOREBOARD_EN
    logic [31:1] busy_reg;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = issue_valid && (issue_rd == 5'(gi));
            assign clr_bit = rf_wr_reg && (rf_a2_reg == 5'(gi));
            // Set beats clear so a re-issue on the retiring edge stays pending.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    busy_reg[gi] <= 1'b0;
                end else if (set_bit) begin
                    busy_reg[gi] <= 1'b1;
                end else if (clr_bit) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign busy = {busy_reg, 1'b0};
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_rd};
    assign busy = 32'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: handshake, aging fairness, x0 writes, scoreboard, async reset.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [4:0]  rf_a2;
    logic [31:0] rf_din;
    logic        rf_reg_wr;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;

    int n_checks = 0;
    int n_errors = 0;

`ifdef WB_SCOREBOARD_EN
    localparam logic [31:0] BUSY7 = 32'h0000_0080;
`else
    localparam logic [31:0] BUSY7 = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(.MAX_WAIT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .ex_ready   (ex_ready),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .rf_a2      (rf_a2),
        .rf_din     (rf_din),
        .rf_reg_wr  (rf_reg_wr),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_data = 32'd0;
        ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h55;
        issue_valid = 1'b0; issue_rd = 5'd0;

        // Reset state, with a request pending that must not be accepted
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr", {31'd0, rf_reg_wr}, 32'd0);
        check("rst_a2", {27'd0, rf_a2}, 32'd0);
        check("rst_din", rf_din, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Single load request
        ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hDEADBEEF;
        #1;
        check("ld_ready", {31'd0, ld_ready}, 32'd1);
        check("ld_ex_ready", {31'd0, ex_ready}, 32'd0);
        tick();
        ld_valid = 1'b0;
        check("ld_wr", {31'd0, rf_reg_wr}, 32'd1);
        check("ld_a2", {27'd0, rf_a2}, 32'd5);
        check("ld_din", rf_din, 32'hDEADBEEF);
        tick();
        check("ld_wr_off", {31'd0, rf_reg_wr}, 32'd0);
        check("ld_a2_hold", {27'd0, rf_a2}, 32'd5);
        check("ld_din_hold", rf_din, 32'hDEADBEEF);

        // Both sources continuously valid: L L L E repeating
        ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h1111;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h2222;
        for (int i = 0; i < 8; i++) begin
            logic exp_ld;
            exp_ld = ((i % 4) != 3);
            #1;
            check($sformatf("fair%0d_ld_ready", i), {31'd0, ld_ready}, {31'd0, exp_ld});
            check($sformatf("fair%0d_ex_ready", i), {31'd0, ex_ready}, {31'd0, !exp_ld});
            tick();
            check($sformatf("fair%0d_a2", i), {27'd0, rf_a2}, exp_ld ? 32'd4 : 32'd3);
            check($sformatf("fair%0d_din", i), rf_din, exp_ld ? 32'h2222 : 32'h1111);
        end
        ld_valid = 1'b0;

        // Execute write to x0 is consumed without a register file write
        ex_rd = 5'd0; ex_data = 32'h1234;
        #1;
        check("x0_ex_ready", {31'd0, ex_ready}, 32'd1);
        tick();
        ex_valid = 1'b0;
        check("x0_wr", {31'd0, rf_reg_wr}, 32'd0);
        check("x0_din", rf_din, 32'h1234);

        // Execute alone
        ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'hABCD;
        #1;
        check("ex_ready", {31'd0, ex_ready}, 32'd1);
        tick();
        ex_valid = 1'b0;
        check("ex_wr", {31'd0, rf_reg_wr}, 32'd1);
        check("ex_a2", {27'd0, rf_a2}, 32'd9);
        tick();

        // Scoreboard: set, retire, and set-wins-over-clear
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_rd = 5'd0;
        check("sb_set7", busy, BUSY7);
        tick();
        issue_valid = 1'b0;
        check("sb_x0_ignored", busy, BUSY7);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        tick();
        ld_valid = 1'b0;
        check("sb_wr7", {31'd0, rf_reg_wr}, 32'd1);
        check("sb_still7", busy, BUSY7);
        tick();
        check("sb_clear7", busy, 32'd0);

        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        check("sb_set_wins", busy, BUSY7);

        // Asynchronous reset while a write is in flight
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hCAFE;
        tick();
        check("pre_rst_wr", {31'd0, rf_reg_wr}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_wr", {31'd0, rf_reg_wr}, 32'd0);
        check("arst_a2", {27'd0, rf_a2}, 32'd0);
        check("arst_din", rf_din, 32'd0);
        check("arst_busy", busy, 32'd0);
        check("arst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("arst_ex_ready", {31'd0, ex_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_ld_ready", {31'd0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0;
        check("rel_wr", {31'd0, rf_reg_wr}, 32'd1);
        check("rel_a2", {27'd0, rf_a2}, 32'd12);
        check("rel_din", rf_din, 32'hCAFE);
        tick();
        check("rel_wr_off", {31'd0, rf_reg_wr}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
